// File: rtl/pay_timer_display.sv
// pay_timer_display: payment session countdown with a scanned 8-digit
// seven-segment display (countdown on digits 7/6, scrolling message on 5..0).
module pay_timer_display #(
   parameter int unsigned SCAN_DIV    = 25000,
   parameter int unsigned TICK_DIV    = 100000000,
   parameter int unsigned ROLL_DIV    = 35000000,
   parameter int unsigned TIMEOUT_SEC = 30,
   parameter int unsigned WARN_SEC    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       cancel,
   input  logic [3:0] paidten,
   input  logic [3:0] paidone,
   input  logic [3:0] costten,
   input  logic [3:0] costone,
   output logic [7:0] seg_en,
   output logic [7:0] seg_out,
   output logic       busy,
   output logic       paid_ok,
   output logic       timeout,
   output logic [3:0] remain_tens,
   output logic [3:0] remain_ones
);

   localparam int unsigned SCAN_W   = $clog2(SCAN_DIV + 1);
   localparam int unsigned TICK_W   = $clog2(TICK_DIV + 1);
   localparam int unsigned HALF_DIV = TICK_DIV / 2;
   localparam int unsigned HALF_W   = $clog2(HALF_DIV + 1);
   localparam int unsigned ROLL_W   = $clog2(ROLL_DIV + 1);

   localparam logic [3:0] INIT_TENS = 4'(TIMEOUT_SEC / 10);
   localparam logic [3:0] INIT_ONES = 4'(TIMEOUT_SEC % 10);

   // glyphs, positive logic {g,f,e,d,c,b,a}
   localparam logic [6:0] G_T     = 7'h78;
   localparam logic [6:0] G_O     = 7'h3F;
   localparam logic [6:0] G_A     = 7'h77;
   localparam logic [6:0] G_L     = 7'h38;
   localparam logic [6:0] G_P     = 7'h73;
   localparam logic [6:0] G_Y     = 7'h6E;
   localparam logic [6:0] G_BLANK = 7'h00;
   localparam logic [6:0] G_DASH  = 7'h40;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE_OK, S_TIMEOUT} state_t;

   state_t            state;
   state_t            state_n;
   logic              load;
   logic              dec;
   logic              tick;
   logic              pay_match;
   logic              remain_zero;
   logic              blank_warn;
   logic              digits_ok;
   logic [6:0]        paid_val;
   logic [6:0]        cost_val;
   logic [6:0]        remain_val;
   logic [SCAN_W-1:0] scan_div;
   logic [2:0]        scan_cnt;
   logic [TICK_W-1:0] tick_cnt;
   logic [HALF_W-1:0] half_cnt;
   logic              blink;
   logic [ROLL_W-1:0] roll_cnt;
   logic [3:0]        offset;
   logic [3:0]        msg_idx;
   logic [6:0]        glyph;
   logic [7:0]        en_n;
   logic [7:0]        seg_n;

   function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'h3F;
         4'd1:    g = 7'h06;
         4'd2:    g = 7'h5B;
         4'd3:    g = 7'h4F;
         4'd4:    g = 7'h66;
         4'd5:    g = 7'h6D;
         4'd6:    g = 7'h7D;
         4'd7:    g = 7'h07;
         4'd8:    g = 7'h7F;
         4'd9:    g = 7'h6F;
         default: g = G_DASH;
      endcase
      return g;
   endfunction

   // payment comparison; any non-BCD digit forces it false
   assign digits_ok   = (paidten <= 4'd9) && (paidone <= 4'd9) &&
                        (costten <= 4'd9) && (costone <= 4'd9);
   assign paid_val    = {3'b000, paidten} * 7'd10 + {3'b000, paidone};
   assign cost_val    = {3'b000, costten} * 7'd10 + {3'b000, costone};
   assign remain_val  = {3'b000, remain_tens} * 7'd10 + {3'b000, remain_ones};
   assign pay_match   = digits_ok && (paid_val >= cost_val);
   assign remain_zero = (remain_tens == 4'd0) && (remain_ones == 4'd0);
   assign tick        = (state == S_RUN) && (tick_cnt == TICK_W'(TICK_DIV - 1));
   assign blank_warn  = blink && (((state == S_RUN) && (remain_val <= 7'(WARN_SEC))) ||
                                  (state == S_TIMEOUT));

   // session state register plus registered status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         paid_ok <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_n;
         busy    <= (state_n == S_RUN);
         paid_ok <= (state_n == S_DONE_OK);
         timeout <= (state_n == S_TIMEOUT);
      end
   end

   // next state: cancel first, then payment over timeout over decrement
   always_comb begin
      state_n = state;
      load    = 1'b0;
      dec     = 1'b0;
      if (cancel) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_RUN: begin
               if (pay_match)        state_n = S_DONE_OK;
               else if (remain_zero) state_n = S_TIMEOUT;
               else if (tick)        dec     = 1'b1;
            end
            default: begin
               if (start) begin
                  state_n = S_RUN;
                  load    = 1'b1;
               end
            end
         endcase
      end
   end

   // BCD remaining seconds
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         remain_tens <= INIT_TENS;
         remain_ones <= INIT_ONES;
      end else if (load) begin
         remain_tens <= INIT_TENS;
         remain_ones <= INIT_ONES;
      end else if (dec) begin
         if (remain_ones == 4'd0) begin
            remain_ones <= 4'd9;
            remain_tens <= remain_tens - 4'd1;
         end else begin
            remain_ones <= remain_ones - 4'd1;
         end
      end
   end

   // one-second prescaler, runs only in RUN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 tick_cnt <= '0;
      else if (load || tick)    tick_cnt <= '0;
      else if (state == S_RUN)  tick_cnt <= tick_cnt + TICK_W'(1);
   end

   // half-second blink phase, runs in every active state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         half_cnt <= '0;
         blink    <= 1'b0;
      end else if (load) begin
         half_cnt <= '0;
         blink    <= 1'b0;
      end else if (state != S_IDLE) begin
         if (half_cnt == HALF_W'(HALF_DIV - 1)) begin
            half_cnt <= '0;
            blink    <= ~blink;
         end else begin
            half_cnt <= half_cnt + HALF_W'(1);
         end
      end
   end

   // message scroll offset, frozen once timed out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         roll_cnt <= '0;
         offset   <= 4'd0;
      end else if (load) begin
         roll_cnt <= '0;
         offset   <= 4'd0;
      end else if ((state == S_RUN) || (state == S_DONE_OK)) begin
         if (roll_cnt == ROLL_W'(ROLL_DIV - 1)) begin
            roll_cnt <= '0;
            offset   <= offset + 4'd1;
         end else begin
            roll_cnt <= roll_cnt + ROLL_W'(1);
         end
      end
   end

   // free-running digit scan
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_div <= '0;
         scan_cnt <= 3'd0;
      end else if (scan_div == SCAN_W'(SCAN_DIV - 1)) begin
         scan_div <= '0;
         scan_cnt <= scan_cnt + 3'd1;
      end else begin
         scan_div <= scan_div + SCAN_W'(1);
      end
   end

   // select glyph for the digit currently being scanned
   always_comb begin
      en_n    = 8'hFF;
      seg_n   = 8'hFF;
      glyph   = G_BLANK;
      msg_idx = 4'(offset + 4'd5 - {1'b0, scan_cnt});
      case (msg_idx)
         4'd0:    glyph = G_T;
         4'd1:    glyph = G_O;
         4'd2:    glyph = G_T;
         4'd3:    glyph = G_A;
         4'd4:    glyph = G_L;
         4'd6:    glyph = bcd_glyph(costten);
         4'd7:    glyph = bcd_glyph(costone);
         4'd9:    glyph = G_P;
         4'd10:   glyph = G_A;
         4'd11:   glyph = G_Y;
         4'd13:   glyph = bcd_glyph(paidten);
         4'd14:   glyph = bcd_glyph(paidone);
         default: glyph = G_BLANK;
      endcase
      if (scan_cnt == 3'd7)      glyph = blank_warn ? G_BLANK : bcd_glyph(remain_tens);
      else if (scan_cnt == 3'd6) glyph = blank_warn ? G_BLANK : bcd_glyph(remain_ones);
      if (state != S_IDLE) begin
         en_n  = ~(8'd1 << scan_cnt);
         seg_n = {1'b1, ~glyph};
      end
   end

   // registered display drive
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_en  <= 8'hFF;
         seg_out <= 8'hFF;
      end else begin
         seg_en  <= en_n;
         seg_out <= seg_n;
      end
   end

endmodule

// File: tb/tb_pay_timer_display.sv
// Bench for pay_timer_display: directed sessions then random traffic,
// checked cycle by cycle against an arithmetic model through a scoreboard.
module tb_pay_timer_display;

   localparam int SCAN_DIV    = 2;
   localparam int TICK_DIV    = 20;
   localparam int ROLL_DIV    = 40;
   localparam int TIMEOUT_SEC = 3;
   localparam int WARN_SEC    = 1;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_OK   = 2;
   localparam int M_TO   = 3;

   localparam logic [6:0] DIG [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   typedef struct {
      logic [7:0] en;
      logic [7:0] seg;
      logic       busy;
      logic       ok;
      logic       to;
      logic [3:0] rt;
      logic [3:0] ro;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       cancel = 1'b0;
   logic [3:0] paidten = 4'd0;
   logic [3:0] paidone = 4'd0;
   logic [3:0] costten = 4'd0;
   logic [3:0] costone = 4'd0;
   logic [7:0] seg_en;
   logic [7:0] seg_out;
   logic       busy;
   logic       paid_ok;
   logic       timeout;
   logic [3:0] remain_tens;
   logic [3:0] remain_ones;

   // requested input values, applied at the next drive point
   logic       d_rst = 1'b0;
   logic [3:0] d_pt = 4'd0;
   logic [3:0] d_po = 4'd0;
   logic [3:0] d_ct = 4'd0;
   logic [3:0] d_co = 4'd0;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model: session state and elapsed-cycle counts
   int m_st, m_remain, m_run, m_act, m_roll, m_cyc;

   pay_timer_display #(
      .SCAN_DIV(SCAN_DIV), .TICK_DIV(TICK_DIV), .ROLL_DIV(ROLL_DIV),
      .TIMEOUT_SEC(TIMEOUT_SEC), .WARN_SEC(WARN_SEC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cancel(cancel),
      .paidten(paidten), .paidone(paidone), .costten(costten), .costone(costone),
      .seg_en(seg_en), .seg_out(seg_out), .busy(busy), .paid_ok(paid_ok),
      .timeout(timeout), .remain_tens(remain_tens), .remain_ones(remain_ones)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [7:0] got, input logic [7:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, got, want);
      end
   endfunction

   function automatic logic [6:0] dig_gly(input int v);
      return (v > 9) ? 7'h40 : DIG[v];
   endfunction

   function automatic logic [6:0] char_gly(input byte ch);
      case (ch)
         "T":     return 7'h78;
         "O":     return 7'h3F;
         "A":     return 7'h77;
         "L":     return 7'h38;
         "P":     return 7'h73;
         "Y":     return 7'h6E;
         default: return 7'h00;
      endcase
   endfunction

   // message is a text template with placeholders for the amount digits
   function automatic logic [6:0] msg_gly(input int i);
      string tmpl;
      tmpl = "TOTAL ?? PAY ?? ";
      case (i)
         6:       return dig_gly(int'(costten));
         7:       return dig_gly(int'(costone));
         13:      return dig_gly(int'(paidten));
         14:      return dig_gly(int'(paidone));
         default: return char_gly(tmpl[i]);
      endcase
   endfunction

   function automatic void model_reset();
      m_st = M_IDLE; m_remain = TIMEOUT_SEC;
      m_run = 0; m_act = 0; m_roll = 0; m_cyc = 0;
   endfunction

   function automatic exp_t reset_exp();
      exp_t e;
      e.en = 8'hFF; e.seg = 8'hFF; e.busy = 1'b0; e.ok = 1'b0; e.to = 1'b0;
      e.rt = 4'(TIMEOUT_SEC / 10); e.ro = 4'(TIMEOUT_SEC % 10);
      return e;
   endfunction

   // expected outputs after the coming clock edge given the applied inputs
   function automatic exp_t model_edge();
      exp_t e;
      int scan, off, phase, nxt;
      bit pay, load;
      logic [6:0] g;
      if (!rst) begin
         model_reset();
         return reset_exp();
      end
      scan  = (m_cyc / SCAN_DIV) % 8;
      off   = (m_roll / ROLL_DIV) % 16;
      phase = (m_act / (TICK_DIV / 2)) % 2;
      e.en  = 8'hFF;
      e.seg = 8'hFF;
      if (m_st != M_IDLE) begin
         e.en[scan] = 1'b0;
         if (scan >= 6) begin
            if (phase == 1 && ((m_st == M_RUN && m_remain <= WARN_SEC) || m_st == M_TO))
               g = 7'h00;
            else
               g = dig_gly(scan == 7 ? m_remain / 10 : m_remain % 10);
         end else begin
            g = msg_gly((off + 5 - scan) % 16);
         end
         e.seg = {1'b1, ~g};
      end
      pay = (paidten <= 9) && (paidone <= 9) && (costten <= 9) && (costone <= 9) &&
            (int'(paidten) * 10 + int'(paidone) >= int'(costten) * 10 + int'(costone));
      load = 1'b0;
      nxt  = m_st;
      if (cancel) nxt = M_IDLE;
      else if (m_st == M_RUN) begin
         if (pay) nxt = M_OK;
         else if (m_remain == 0) nxt = M_TO;
         else begin
            m_run++;
            m_remain = TIMEOUT_SEC - m_run / TICK_DIV;
         end
      end else if (start) begin
         nxt  = M_RUN;
         load = 1'b1;
      end
      if (load) begin
         m_run = 0; m_act = 0; m_roll = 0; m_remain = TIMEOUT_SEC;
      end else begin
         if (m_st != M_IDLE) m_act++;
         if (m_st == M_RUN || m_st == M_OK) m_roll++;
      end
      m_cyc++;
      m_st   = nxt;
      e.busy = (m_st == M_RUN);
      e.ok   = (m_st == M_OK);
      e.to   = (m_st == M_TO);
      e.rt   = 4'(m_remain / 10);
      e.ro   = 4'(m_remain % 10);
      return e;
   endfunction

   // drive one cycle of stimulus and queue its expected response
   task automatic cyc(input logic s, input logic c);
      exp_t e;
      logic was_rst;
      @(negedge clk);
      was_rst = rst;
      rst = d_rst; start = s; cancel = c;
      paidten = d_pt; paidone = d_po; costten = d_ct; costone = d_co;
      e = model_edge();
      exp_q.push_back(e);
      if (was_rst && !rst) begin
         #1;
         chk("rst_seg_en", seg_en, 8'hFF);
         chk("rst_seg_out", seg_out, 8'hFF);
         chk("rst_busy", 8'(busy), 8'h00);
         chk("rst_paid_ok", 8'(paid_ok), 8'h00);
         chk("rst_timeout", 8'(timeout), 8'h00);
         chk("rst_remain", {remain_tens, remain_ones}, 8'h03);
      end
   endtask

   // monitor: the display and status update every cycle
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("seg_en", seg_en, e.en);
            chk("seg_out", seg_out, e.seg);
            chk("busy", 8'(busy), 8'(e.busy));
            chk("paid_ok", 8'(paid_ok), 8'(e.ok));
            chk("timeout", 8'(timeout), 8'(e.to));
            chk("remain", {remain_tens, remain_ones}, {e.rt, e.ro});
         end
      end
   end

   initial begin
      int r;
      model_reset();
      repeat (3) cyc(1'b0, 1'b0);
      d_rst = 1'b1;
      repeat (2) cyc(1'b0, 1'b0);

      // unpaid session runs out
      d_ct = 4'd1; d_co = 4'd2; d_pt = 4'd0; d_po = 4'd0;
      cyc(1'b1, 1'b0);
      repeat (90) cyc(1'b0, 1'b0);

      // payment arrives part way through
      cyc(1'b1, 1'b0);
      repeat (30) cyc(1'b0, 1'b0);
      d_pt = 4'd1; d_po = 4'd5;
      repeat (100) cyc(1'b0, 1'b0);

      // exact payment on the cycle the countdown hits zero
      d_pt = 4'd0; d_po = 4'd0;
      cyc(1'b1, 1'b0);
      repeat (60) cyc(1'b0, 1'b0);
      d_pt = 4'd1; d_po = 4'd2;
      repeat (10) cyc(1'b0, 1'b0);

      // cancel together with start while running
      d_pt = 4'd0; d_po = 4'd0;
      cyc(1'b1, 1'b0);
      repeat (15) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b1);
      repeat (5) cyc(1'b0, 1'b0);

      // reset mid-session
      cyc(1'b1, 1'b0);
      repeat (25) cyc(1'b0, 1'b0);
      d_rst = 1'b0;
      repeat (2) cyc(1'b0, 1'b0);
      d_rst = 1'b1;
      repeat (5) cyc(1'b0, 1'b0);

      // non-BCD cost digit never pays
      d_co = 4'hA; d_pt = 4'd9; d_po = 4'd9;
      cyc(1'b1, 1'b0);
      repeat (100) cyc(1'b0, 1'b0);

      // random traffic
      repeat (3000) begin
         if ($urandom_range(0, 39) == 0) d_pt = 4'($urandom_range(0, 11));
         if ($urandom_range(0, 39) == 0) d_po = 4'($urandom_range(0, 11));
         if ($urandom_range(0, 59) == 0) d_ct = 4'($urandom_range(0, 11));
         if ($urandom_range(0, 59) == 0) d_co = 4'($urandom_range(0, 11));
         if ($urandom_range(0, 599) == 0) begin
            d_rst = 1'b0;
            repeat (2) cyc(1'b0, 1'b0);
            d_rst = 1'b1;
         end
         r = $urandom_range(0, 99);
         cyc(r < 3, r == 50);
      end

      repeat (2) cyc(1'b0, 1'b0);
      @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pay_timer_display.md
PAY_TIMER_DISPLAY -- requirements
Module: pay_timer_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 25000, clk cycles per digit-scan step (>=2).
REQ-002 The block SHALL have parameter TICK_DIV, default 100000000, clk cycles per countdown second (>=4, even).
REQ-003 The block SHALL have parameter ROLL_DIV, default 35000000, clk cycles per scroll step (>=1).
REQ-004 The block SHALL have parameter TIMEOUT_SEC, default 30, countdown start value (1..99).
REQ-005 The block SHALL have parameter WARN_SEC, default 5, remaining time at or below which countdown digits blink (0..TIMEOUT_SEC).
REQ-006 The block SHALL have ports: clk  in  1  system clock; one clock, all logic on rising edge.
REQ-007 The block SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-008 The block SHALL have ports: start  in  1  one-cycle pulse, begin payment session.
REQ-009 The block SHALL have ports: cancel  in  1  one-cycle pulse, abort session.
REQ-010 The block SHALL have ports: paidten, paidone, costten, costone  in  4 each  BCD amounts.
REQ-011 The block SHALL have ports: seg_en  out  8  digit enables, active-low, bit7 = leftmost.
REQ-012 The block SHALL have ports: seg_out  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-013 The block SHALL have ports: busy, paid_ok, timeout  out  1 each  session status.
REQ-014 The block SHALL have ports: remain_tens, remain_ones  out  4 each  BCD remaining seconds.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE_OK, TIMEOUT; busy=1 only in RUN; paid_ok=1 only in DONE_OK; timeout=1 only in TIMEOUT.
REQ-016 start in IDLE, DONE_OK or TIMEOUT SHALL enter RUN next cycle, load remain=TIMEOUT_SEC, clear tick prescaler, scroll offset, blink phase; start in RUN ignored.
REQ-017 cancel in any state SHALL go to IDLE next cycle; cancel wins over simultaneous start.
REQ-018 In RUN, remain SHALL decrement by 1 (BCD, ones 0 -> 9 with tens-1) every TICK_DIV cycles of RUN.
REQ-019 In RUN, when remain==00, next state SHALL be TIMEOUT; remain never wraps below 00.
REQ-020 In RUN, paid value (10*paidten+paidone) >= cost value SHALL move to DONE_OK next cycle, remain frozen; payment check takes priority over a same-cycle timeout or decrement.
REQ-021 Any BCD input digit >9 SHALL make the comparison false and show that digit as dash (g only).
REQ-022 Scan counter SHALL advance 0..7 every SCAN_DIV cycles, wrap 7 -> 0; exactly one seg_en bit low per step, bit index = scan count, in all non-IDLE states.
REQ-023 In IDLE, seg_en SHALL be 8'hFF and seg_out 8'hFF.
REQ-024 Digits 7/6 SHALL show remain_tens/remain_ones.
REQ-025 Message SHALL be 16 chars, index 0..15: T,O,T,A,L,blank,costten,costone,blank,P,A,Y,blank,paidten,paidone,blank.
REQ-026 Digit i (5..0) SHALL show message[(offset + 5 - i) mod 16].
REQ-027 Offset SHALL increment mod 16 every ROLL_DIV cycles in RUN and DONE_OK, frozen in TIMEOUT.
REQ-028 Blink phase SHALL toggle every TICK_DIV/2 cycles; in RUN with remain<=WARN_SEC and in TIMEOUT, digits 7/6 SHALL be blank (seg_out 8'hFF) during phase 1.
REQ-029 Glyphs (positive logic, gfedcba): 0-9 standard, T=0000111? no: T=1111000, O=0111111, A=1110111, L=0111000, P=1110011, Y=1101110, blank=0000000; dp always off.
REQ-030 seg_en and seg_out SHALL be registered; display update latency one cycle after scan/offset change.

Reset
REQ-031 rst low SHALL asynchronously force IDLE, remain=TIMEOUT_SEC, all counters/offset/blink phase 0, busy=paid_ok=timeout=0, seg_en=8'hFF, seg_out=8'hFF.
REQ-032 Reset asserted mid-RUN SHALL discard the session; after release the block waits in IDLE for start.

Verification (SCAN_DIV=2, TICK_DIV=20, ROLL_DIV=40, TIMEOUT_SEC=3, WARN_SEC=1)
REQ-033 Reset then start, cost=12, paid=00 -> busy=1; remain 03,02,01,00 at 20-cycle steps; TIMEOUT 1 cycle after 00; timeout=1, remain=00.
REQ-034 Start, cost=12, paid set to 15 after 30 cycles -> paid_ok=1 next cycle, remain frozen at 02, busy=0.
REQ-035 paid=12 equals cost=12 in the same cycle remain reaches 00 -> DONE_OK, not TIMEOUT.
REQ-036 In RUN, sample seg_en over 16 cycles -> FE,FD,...,7F each held 2 cycles; after 40 cycles digit 5 shows O (offset 1).
REQ-037 cancel concurrent with start during RUN -> IDLE, seg_en=FF; rst pulsed mid-RUN -> all outputs at reset values immediately.
REQ-038 costone=4'hA -> digit shows dash, paid_ok never asserts.
